// File: rtl/sram_responder.sv
// sram_responder: word-addressed SRAM model answering a CPU single-port
// interface. It has a synchronous write, a registered one-cycle read-first
// read, a reset-time preload port, a saturating write counter, and a sticky
// out-of-range error capture.
module sram_responder #(
  parameter logic [31:0] ADDR_BASE  = 32'h1c00_0000,
  parameter int          DEPTH_LOG2 = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sram_we,
  input  logic [31:0] sram_addr,
  input  logic [31:0] sram_wdata,
  output logic [31:0] sram_rdata,
  input  logic        init_we,
  input  logic [31:0] init_addr,
  input  logic [31:0] init_wdata,
  output logic [31:0] wr_cnt,
  output logic        err_oor,
  output logic [31:0] err_addr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] mem [DEPTH];

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hffff_ffff) ? v : v + 32'd1;
  endfunction

  logic [31:0]           cpu_off_p0;
  logic [31:0]           init_off_p0;
  logic                  cpu_hit_p0;
  logic                  init_hit_p0;
  logic [DEPTH_LOG2-1:0] cpu_idx_p0;
  logic [DEPTH_LOG2-1:0] init_idx_p0;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_idx;
  logic [31:0]           mem_wdata;
  logic                  unused_byte_lanes;

  // Address decode, stage p0: the offset wraps modulo 2^32, so addresses
  // below the base land far out of range rather than aliasing into the array.
  always_comb begin
    cpu_off_p0  = sram_addr - ADDR_BASE;
    init_off_p0 = init_addr - ADDR_BASE;
    cpu_hit_p0  = (cpu_off_p0[31:DEPTH_LOG2+2] == '0);
    init_hit_p0 = (init_off_p0[31:DEPTH_LOG2+2] == '0);
    cpu_idx_p0  = cpu_off_p0[DEPTH_LOG2+1:2];
    init_idx_p0 = init_off_p0[DEPTH_LOG2+1:2];
  end

  // Byte lanes select nothing: unaligned addresses map to the containing word.
  assign unused_byte_lanes = &{1'b0, cpu_off_p0[1:0], init_off_p0[1:0]};

  // Write-port mux: the preload owns the array during reset, the CPU otherwise.
  always_comb begin
    mem_we    = 1'b0;
    mem_idx   = cpu_idx_p0;
    mem_wdata = sram_wdata;
    if (reset) begin
      mem_we    = init_we && init_hit_p0;
      mem_idx   = init_idx_p0;
      mem_wdata = init_wdata;
    end else begin
      mem_we    = sram_we && cpu_hit_p0;
    end
  end

  // Storage array: never cleared, so contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_idx] <= mem_wdata;
    end
  end

  // Registered read and status, stage p1. The read samples the array before
  // this edge's write lands, which gives read-first behaviour on a collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      sram_rdata <= 32'h0;
      wr_cnt     <= 32'h0;
      err_oor    <= 1'b0;
      err_addr   <= 32'h0;
    end else if (cpu_hit_p0) begin
      sram_rdata <= mem[cpu_idx_p0];
      if (sram_we) begin
        wr_cnt <= sat_inc(wr_cnt);
      end
    end else begin
      sram_rdata <= 32'h0;
      err_oor    <= 1'b1;
      if (!err_oor) begin
        err_addr <= sram_addr;
      end
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Testbench for sram_responder: directed scenarios followed by random traffic,
// all checked against an address-level behavioural model of the responder.
module tb_sram_responder;

  localparam logic [31:0] BASE = 32'h1c00_0000;
  localparam int          WORDS = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic        init_we;
  logic [31:0] init_addr;
  logic [31:0] init_wdata;
  logic [31:0] wr_cnt;
  logic        err_oor;
  logic [31:0] err_addr;

  sram_responder #(.ADDR_BASE(BASE), .DEPTH_LOG2(12)) dut (
    .clk(clk), .reset(reset),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata),
    .init_we(init_we), .init_addr(init_addr), .init_wdata(init_wdata),
    .wr_cnt(wr_cnt), .err_oor(err_oor), .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model state.
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] exp_rdata;
  bit          exp_rdata_known;
  logic [31:0] exp_cnt;
  logic        exp_err;
  logic [31:0] exp_eaddr;

  function automatic bit ref_in_range(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off < WORDS * 4;
  endfunction

  function automatic int unsigned ref_word(input logic [31:0] a);
    logic [31:0] off;
    off = a - BASE;
    return off / 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then check.
  task automatic step(input bit rst, input bit we, input logic [31:0] a,
                      input logic [31:0] wd, input bit iwe,
                      input logic [31:0] ia, input logic [31:0] iwd);
    int unsigned w;
    reset = rst; sram_we = we; sram_addr = a; sram_wdata = wd;
    init_we = iwe; init_addr = ia; init_wdata = iwd;
    @(posedge clk);
    if (rst) begin
      exp_rdata = 32'h0; exp_rdata_known = 1'b1;
      exp_cnt = 32'h0; exp_err = 1'b0; exp_eaddr = 32'h0;
      if (iwe && ref_in_range(ia)) ref_mem[ref_word(ia)] = iwd;
    end else if (ref_in_range(a)) begin
      w = ref_word(a);
      exp_rdata_known = ref_mem.exists(w);
      exp_rdata = exp_rdata_known ? ref_mem[w] : 32'h0;
      if (we) begin
        ref_mem[w] = wd;
        if (exp_cnt != 32'hffff_ffff) exp_cnt = exp_cnt + 1;
      end
    end else begin
      exp_rdata = 32'h0; exp_rdata_known = 1'b1;
      if (!exp_err) exp_eaddr = a;
      exp_err = 1'b1;
    end
    #1;
    if (exp_rdata_known) chk("rdata", sram_rdata, exp_rdata);
    chk("wr_cnt", wr_cnt, exp_cnt);
    chk("err_oor", {31'b0, err_oor}, {31'b0, exp_err});
    chk("err_addr", err_addr, exp_eaddr);
  endtask

  task automatic cpu(input bit we, input logic [31:0] a, input logic [31:0] wd);
    step(1'b0, we, a, wd, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b1, a, d);
  endtask

  initial begin
    logic [31:0] ra, rd, rnd;
    reset = 1'b1; sram_we = 1'b0; sram_addr = 32'h0; sram_wdata = 32'h0;
    init_we = 1'b0; init_addr = 32'h0; init_wdata = 32'h0;
    exp_rdata = 32'h0; exp_rdata_known = 1'b0;
    exp_cnt = 32'h0; exp_err = 1'b0; exp_eaddr = 32'h0;
    @(negedge clk);

    // Reset state, with a plain reset cycle and no preload.
    step(1'b1, 1'b1, BASE, 32'hffff_ffff, 1'b0, 32'h0, 32'h0);
    chk("reset_rdata", sram_rdata, 32'h0);
    chk("reset_cnt", wr_cnt, 32'h0);

    // Preload a 64-word window with random data, then the two program words.
    for (int i = 0; i < 64; i++) preload(BASE + 32'(i * 4), $urandom);
    preload(BASE, 32'h0280_0401);
    preload(BASE + 32'h4, 32'h0280_0802);
    // An out-of-range preload is dropped and leaves the error flag clear.
    preload(BASE + 32'h4000, 32'hcafe_cafe);
    chk("preload_oor_noerr", {31'b0, err_oor}, 32'h0);

    cpu(1'b0, BASE, 32'h0);
    chk("preload_w0", sram_rdata, 32'h0280_0401);
    cpu(1'b0, BASE + 32'h4, 32'h0);
    chk("preload_w1", sram_rdata, 32'h0280_0802);
    chk("preload_cnt", wr_cnt, 32'h0);

    // Write, then read-first collision on the same word.
    cpu(1'b1, 32'h1c00_0100, 32'hdead_beef);
    cpu(1'b1, 32'h1c00_0100, 32'h1234_5678);
    chk("collision_old", sram_rdata, 32'hdead_beef);
    cpu(1'b0, 32'h1c00_0100, 32'h0);
    chk("collision_new", sram_rdata, 32'h1234_5678);
    chk("collision_cnt", wr_cnt, 32'd2);

    // Unaligned address aliases to its containing word.
    cpu(1'b1, 32'h1c00_0203, 32'ha5a5_a5a5);
    cpu(1'b0, 32'h1c00_0200, 32'h0);
    chk("unaligned", sram_rdata, 32'ha5a5_a5a5);
    chk("unaligned_noerr", {31'b0, err_oor}, 32'h0);

    // Out of range just past the top, then just below the base.
    cpu(1'b1, 32'h1c00_4000, 32'h5555_5555);
    chk("oor_hi_rdata", sram_rdata, 32'h0);
    chk("oor_hi_err", {31'b0, err_oor}, 32'h1);
    cpu(1'b0, 32'h1bff_fffc, 32'h0);
    chk("oor_lo_rdata", sram_rdata, 32'h0);
    chk("oor_first_addr", err_addr, 32'h1c00_4000);
    chk("oor_cnt", wr_cnt, 32'd3);

    // Bring the counter to 5, then reset with a write pending.
    cpu(1'b1, 32'h1c00_0010, 32'h1111_1111);
    cpu(1'b1, 32'h1c00_0014, 32'h2222_2222);
    chk("pre_reset_cnt", wr_cnt, 32'd5);
    step(1'b1, 1'b1, 32'h1c00_0010, 32'hbad0_bad0, 1'b0, 32'h0, 32'h0);
    chk("midreset_rdata", sram_rdata, 32'h0);
    chk("midreset_cnt", wr_cnt, 32'h0);
    chk("midreset_err", {31'b0, err_oor}, 32'h0);
    chk("midreset_eaddr", err_addr, 32'h0);
    cpu(1'b0, 32'h1c00_0010, 32'h0);
    chk("midreset_lost_write", sram_rdata, 32'h1111_1111);
    cpu(1'b0, 32'h1c00_0100, 32'h0);
    chk("midreset_keep", sram_rdata, 32'h1234_5678);

    // Counter saturation.
    force dut.wr_cnt = 32'hffff_ffff;
    #1;
    release dut.wr_cnt;
    chk("forced_cnt", wr_cnt, 32'hffff_ffff);
    exp_cnt = 32'hffff_ffff;
    cpu(1'b1, 32'h1c00_0020, 32'h5a5a_0000);
    chk("sat_cnt", wr_cnt, 32'hffff_ffff);
    cpu(1'b0, 32'h1c00_0020, 32'h0);
    chk("sat_data", sram_rdata, 32'h5a5a_0000);

    // Random traffic against the model.
    step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 400; i++) begin
      rnd = $urandom_range(0, 99);
      if (rnd < 85)
        ra = BASE + 32'($urandom_range(0, 63) * 4) + 32'($urandom_range(0, 3));
      else if (rnd < 92)
        ra = BASE + 32'h4000 + 32'($urandom_range(0, 255) * 4);
      else
        ra = BASE - 32'h4 - 32'($urandom_range(0, 255) * 4);
      rd = $urandom;
      if ($urandom_range(0, 99) < 4)
        step(1'b1, $urandom_range(0, 1) == 1, ra, rd,
             $urandom_range(0, 1) == 1, ra, ~rd);
      else
        cpu($urandom_range(0, 1) == 1, ra, rd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the CPU's single-port SRAM interface (`*_sram_we/addr/wdata/rdata`). One instance serves the instruction port and one serves the data port of the single-cycle CPU top. Each instance holds a word-addressed storage array with synchronous write and a registered one-cycle read. A reset-time preload port lets the loader fill the array, and a write counter and a sticky out-of-range error flag support bring-up and verification.

## Interface
Parameters:
- `ADDR_BASE`, default 32'h1c00_0000: byte address of word 0.
- `DEPTH_LOG2`, default 12: log2 of the number of 32-bit words (default 4096 words, 16 KiB).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sram_we`  in  1  write strobe from the CPU; full-word write.
- `sram_addr`  in  32  byte address from the CPU.
- `sram_wdata`  in  32  write data.
- `sram_rdata`  out  32  registered read data.
- `init_we`  in  1  preload write strobe; honoured only while `reset`=1.
- `init_addr`  in  32  preload byte address; same mapping as `sram_addr`.
- `init_wdata`  in  32  preload data.
- `wr_cnt`  out  32  number of accepted CPU writes; saturating.
- `err_oor`  out  1  sticky flag: a CPU access fell outside the array.
- `err_addr`  out  32  `sram_addr` of the first out-of-range access.

## Operation
- Offset = `addr - ADDR_BASE`, computed modulo 2^32. An address is in range iff `offset[31:DEPTH_LOG2+2]` == 0.
- Word index = `offset[DEPTH_LOG2+1:2]`. `addr[1:0]` is ignored, so an unaligned address maps to its containing word. This is not an error.
- Normal cycle (`reset`=0):
  - In range and `sram_we`=1: `mem[idx] <= sram_wdata`, and `wr_cnt` increments (holds at 32'hffff_ffff).
  - In range, either value of `sram_we`: `sram_rdata <= mem[idx]`, read-first. A write and a read of the same index in one cycle return the OLD word.
  - Out of range: no write, `wr_cnt` unchanged, `sram_rdata <= 32'h0`. `err_oor <= 1`. If `err_oor` was 0, `err_addr <= sram_addr`; otherwise `err_addr` holds.
  - `init_*` is ignored.
- Reset cycle (`reset`=1):
  - `sram_rdata`, `wr_cnt`, `err_oor` and `err_addr` all load 0.
  - `sram_we` is ignored.
  - If `init_we`=1 and `init_addr` is in range, `mem[idx(init_addr)] <= init_wdata`. An out-of-range preload is dropped silently and does not set `err_oor`.
- The array is NOT cleared by reset. Contents survive reset and are changed only by writes.
- Status outputs are plain registers with no handshake.

## Timing
- Read latency is 1 cycle. An address presented in the cycle before edge N gives data on `sram_rdata` after edge N. The CPU therefore drives `nextpc` (not `pc`) on the instruction port, and its reset trick (`pc` = 32'h1bff_fffc, so `nextpc` = 32'h1c00_0000) makes word 0 appear on the first cycle after reset.
- A write is committed at the same edge it is sampled. A read of that word at the following edge returns the new data (no bypass needed, since write and read are on separate edges).
- Reset values: `sram_rdata`=0, `wr_cnt`=0, `err_oor`=0, `err_addr`=0. These take effect at the first edge with `reset`=1.
- Reset asserted mid-operation: a `sram_we` in that cycle is lost. Outputs are cleared at that edge, and the array keeps all earlier writes.
- `err_oor` and `err_addr` update at the same edge as the offending access.

## Test plan
- Preload under reset: hold `reset`=1, `init_we`=1 with 0x1c00_0000←0x0280_0401 and 0x1c00_0004←0x0280_0802. Release reset and drive addr 0x1c00_0000 then 0x1c00_0004. Expect rdata 0x0280_0401, then 0x0280_0802, each 1 cycle after its address. Expect `wr_cnt`=0.
- Write, then read-first collision: write 0xdead_beef to 0x1c00_0100. Next cycle write 0x1234_5678 to the same address; rdata shows 0xdead_beef. Read again; rdata shows 0x1234_5678. Expect `wr_cnt`=2.
- Unaligned alias: write 0xa5a5_a5a5 to 0x1c00_0203 and read 0x1c00_0200. Expect 0xa5a5_a5a5 and `err_oor`=0.
- Out-of-range access: write to 0x1c00_4000 (just past 16 KiB), then read 0x1bff_fffc. Expect rdata 0 both times and `err_oor`=1. Expect `err_addr`=0x1c00_4000, not overwritten by the second access, and `wr_cnt` unchanged.
- Reset mid-stream: with `wr_cnt`=5 and `err_oor`=1, assert reset for 1 cycle while `sram_we`=1 to 0x1c00_0010. Expect all outputs 0 after that edge. Earlier data is still readable, and 0x1c00_0010 is unchanged.
- Counter saturation: force `wr_cnt` to 32'hffff_ffff (via `$deposit`/force), then write once more. Expect `wr_cnt` to hold 32'hffff_ffff and the data to be stored.
